// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: pin command encodings, controller states and
// helpers for wait-period loads and the mode register word.
package sdram_pkg;

   localparam logic [2:0] CMD_NOP       = 3'b111;
   localparam logic [2:0] CMD_ACTIVE    = 3'b011;
   localparam logic [2:0] CMD_READ      = 3'b101;
   localparam logic [2:0] CMD_WRITE     = 3'b100;
   localparam logic [2:0] CMD_PRECHARGE = 3'b010;
   localparam logic [2:0] CMD_REFRESH   = 3'b001;
   localparam logic [2:0] CMD_MODE      = 3'b000;

   localparam int TIMER_W = 16;

   typedef enum logic [3:0] {
      INIT_WAIT,
      INIT_PRE,
      INIT_REF1,
      INIT_REF2,
      INIT_MODE,
      IDLE,
      ACTIVATE,
      RW,
      RDWAIT,
      PRECH,
      REFRESH
   } sdram_state_t;

   // The timer load is registered, so a wait of N cycles loads N-2.
   function automatic logic [TIMER_W-1:0] wait_load(input int cycles);
      return (cycles > 2) ? TIMER_W'(cycles - 2) : '0;
   endfunction

   // Burst length 1, sequential, CAS latency, write burst follows burst length (single).
   function automatic logic [15:0] mode_reg(input int cas_lat);
      logic [15:0] m;
      m      = '0;
      m[6:4] = 3'(cas_lat);
      return m;
   endfunction

endpackage

// File: rtl/sdram_timer.sv
// Loadable down-counter used for every SDRAM wait period; done is high
// whenever the count has reached zero.
module sdram_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/sdram_ctrl.sv
// Single-access SDRAM controller with power-up init and auto-precharge accesses.
// Define SDRAM_CTRL_REFRESH_EN for periodic refresh; without it no refresh runs after init.
module sdram_ctrl
   import sdram_pkg::*;
#(
   parameter int AWIDTH  = 12,
   parameter int DWIDTH  = 16,
   parameter int CWIDTH  = 8,
   parameter int T_RCD   = 2,
   parameter int T_RP    = 2,
   parameter int T_RFC   = 7,
   parameter int CAS_LAT = 2,
   parameter int T_INIT  = 10000,
   parameter int T_REFI  = 780
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [AWIDTH+CWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0]        req_wdata,
   output logic [DWIDTH-1:0]        rdata,
   output logic                     rvalid,
   output logic                     init_done,
   output logic                     ras_n,
   output logic                     cas_n,
   output logic                     we_n,
   output logic [AWIDTH-1:0]        addr,
   output logic [DWIDTH-1:0]        data_o,
   output logic                     data_oe,
   input  logic [DWIDTH-1:0]        data_i
);

   localparam logic [AWIDTH-1:0] A10_ONLY = AWIDTH'(1 << 10);

   sdram_state_t        state;
   logic [2:0]          cmd;
   logic                tmr_load;
   logic [TIMER_W-1:0]  tmr_val;
   logic                tmr_done;
   logic                wait_done;
   logic                init_armed;
   logic                lat_we;
   logic [AWIDTH-1:0]   lat_row;
   logic [CWIDTH-1:0]   lat_col;
   logic [DWIDTH-1:0]   lat_wdata;
   logic [AWIDTH-1:0]   rw_addr;
   logic                ref_due;
   logic                ref_due_next;

   assign {ras_n, cas_n, we_n} = cmd;

   sdram_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // The timer still shows its old count in the cycle its load is applied.
   assign wait_done = tmr_done && !tmr_load;

   always_comb begin
      rw_addr              = '0;
      rw_addr[CWIDTH-1:0]  = lat_col;
      rw_addr[10]          = 1'b1;
   end

`ifdef SDRAM_CTRL_REFRESH_EN
   localparam int REFI_W = $clog2(T_REFI + 1);

   logic [REFI_W-1:0] ref_cnt;
   logic              ref_pend;
   logic              ref_tick;
   logic              ref_clear;

   assign ref_tick     = init_done && (ref_cnt == REFI_W'(T_REFI - 1));
   assign ref_clear    = (state == IDLE) && ref_pend;
   assign ref_due      = ref_pend;
   assign ref_due_next = ref_pend || ref_tick;

   // Interval counter runs only once init is complete; the pending flag is sticky until serviced.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
      end else begin
         if (init_done) begin
            ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
         end
         if (ref_tick) begin
            ref_pend <= 1'b1;
         end else if (ref_clear) begin
            ref_pend <= 1'b0;
         end
      end
   end
`else
   assign ref_due      = 1'b0;
   assign ref_due_next = 1'b0;
`endif

   // Each state's command appears in its first cycle; req_ready is only raised on entry to an idle cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= INIT_WAIT;
         cmd        <= CMD_NOP;
         addr       <= '0;
         data_o     <= '0;
         data_oe    <= 1'b0;
         rdata      <= '0;
         rvalid     <= 1'b0;
         req_ready  <= 1'b0;
         init_done  <= 1'b0;
         tmr_load   <= 1'b0;
         tmr_val    <= '0;
         init_armed <= 1'b0;
         lat_we     <= 1'b0;
         lat_row    <= '0;
         lat_col    <= '0;
         lat_wdata  <= '0;
      end else begin
         cmd       <= CMD_NOP;
         addr      <= '0;
         data_o    <= '0;
         data_oe   <= 1'b0;
         rvalid    <= 1'b0;
         req_ready <= 1'b0;
         tmr_load  <= 1'b0;
         case (state)
            INIT_WAIT: begin
               if (!init_armed) begin
                  init_armed <= 1'b1;
                  tmr_load   <= 1'b1;
                  tmr_val    <= wait_load(T_INIT - 1);
               end else if (wait_done) begin
                  state    <= INIT_PRE;
                  cmd      <= CMD_PRECHARGE;
                  addr     <= A10_ONLY;
                  tmr_load <= 1'b1;
                  tmr_val  <= wait_load(T_RP);
               end
            end
            INIT_PRE: begin
               if (wait_done) begin
                  state    <= INIT_REF1;
                  cmd      <= CMD_REFRESH;
                  tmr_load <= 1'b1;
                  tmr_val  <= wait_load(T_RFC);
               end
            end
            INIT_REF1: begin
               if (wait_done) begin
                  state    <= INIT_REF2;
                  cmd      <= CMD_REFRESH;
                  tmr_load <= 1'b1;
                  tmr_val  <= wait_load(T_RFC);
               end
            end
            INIT_REF2: begin
               if (wait_done) begin
                  state    <= INIT_MODE;
                  cmd      <= CMD_MODE;
                  addr     <= AWIDTH'(mode_reg(CAS_LAT));
                  tmr_load <= 1'b1;
                  tmr_val  <= wait_load(2);
               end
            end
            INIT_MODE: begin
               if (wait_done) begin
                  state     <= IDLE;
                  init_done <= 1'b1;
                  req_ready <= !ref_due_next;
               end
            end
            IDLE: begin
               if (ref_due) begin
                  state    <= REFRESH;
                  cmd      <= CMD_REFRESH;
                  tmr_load <= 1'b1;
                  tmr_val  <= wait_load(T_RFC);
               end else if (req_valid && req_ready) begin
                  state     <= ACTIVATE;
                  cmd       <= CMD_ACTIVE;
                  addr      <= req_addr[AWIDTH+CWIDTH-1:CWIDTH];
                  lat_we    <= req_we;
                  lat_row   <= req_addr[AWIDTH+CWIDTH-1:CWIDTH];
                  lat_col   <= req_addr[CWIDTH-1:0];
                  lat_wdata <= req_wdata;
                  tmr_load  <= 1'b1;
                  tmr_val   <= wait_load(T_RCD);
               end else begin
                  req_ready <= !ref_due_next;
               end
            end
            ACTIVATE: begin
               if (wait_done) begin
                  state   <= RW;
                  cmd     <= lat_we ? CMD_WRITE : CMD_READ;
                  addr    <= rw_addr;
                  data_oe <= lat_we;
                  data_o  <= lat_we ? lat_wdata : '0;
               end
            end
            RW: begin
               tmr_load <= 1'b1;
               if (lat_we) begin
                  state   <= PRECH;
                  tmr_val <= wait_load(T_RP);
               end else begin
                  state   <= RDWAIT;
                  tmr_val <= wait_load(CAS_LAT + 1);
               end
            end
            RDWAIT: begin
               if (wait_done) begin
                  state    <= PRECH;
                  rdata    <= data_i;
                  rvalid   <= 1'b1;
                  tmr_load <= 1'b1;
                  tmr_val  <= wait_load(T_RP);
               end
            end
            PRECH: begin
               if (wait_done) begin
                  state     <= IDLE;
                  req_ready <= !ref_due_next;
               end
            end
            REFRESH: begin
               if (wait_done) begin
                  state     <= IDLE;
                  req_ready <= !ref_due_next;
               end
            end
            default: begin
               state <= INIT_WAIT;
            end
         endcase
      end
   end

   // lat_row is kept for visibility of the open row alongside the column.
   logic unused_row;
   assign unused_row = ^lat_row;

endmodule
